// File: rtl/cache_pkg.sv
// Shared cache-subsystem constants and the fill controller state type.
// Also consumed by the cache arrays and the main-memory model.
package cache_pkg;
    localparam int LINE_WORDS  = 8;
    localparam int OFFSET_W    = $clog2(LINE_WORDS);
    localparam int MEM_LATENCY = 4;

    typedef enum logic {
        IDLE = 1'b0,
        FILL = 1'b1
    } fill_state_t;
endpackage

// File: rtl/cache_fill_counter.sv
// Up-counter with synchronous clear and enable; clear has priority over enable.
module cache_fill_counter #(
    parameter int W = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         clr,
    input  logic         en,
    output logic [W-1:0] cnt
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)   cnt <= '0;
        else if (clr) cnt <= '0;
        else if (en)  cnt <= cnt + W'(1);
    end
endmodule

// File: rtl/dff.sv
// Generic register cell with asynchronous active-low reset to a parameterised value.
module dff #(
    parameter int             W       = 1,
    parameter logic [W-1:0]   RST_VAL = '0
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [W-1:0] d,
    output logic [W-1:0] q
);
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) q <= RST_VAL;
        else        q <= d;
    end
endmodule

// File: rtl/cache_fill_fsm.sv
// Cache miss fill controller: stalls the pipeline, streams one line from main memory
// into the data array with issue and receive overlapped, then writes the tag.
module cache_fill_fsm #(
    parameter int ADDR_WIDTH = 16,
    parameter int DATA_WIDTH = 16,
    parameter int LINE_WORDS = 8
) (
    input  logic                            clk,
    input  logic                            rst_n,
    input  logic                            miss_detected,
    input  logic [ADDR_WIDTH-1:0]           miss_address,
    input  logic                            memory_data_valid,
    input  logic [DATA_WIDTH-1:0]           memory_data_out,
    output logic                            fsm_busy,
    output logic                            mem_read,
    output logic [ADDR_WIDTH-1:0]           memory_address,
    output logic                            write_data_array,
    output logic [$clog2(LINE_WORDS)-1:0]   cache_word_offset,
    output logic [DATA_WIDTH-1:0]           cache_write_data,
    output logic                            write_tag_array,
    output logic [ADDR_WIDTH-1:0]           fill_line_address
);
    import cache_pkg::fill_state_t;
    import cache_pkg::IDLE;
    import cache_pkg::FILL;

    localparam int OW = $clog2(LINE_WORDS);
    localparam int CW = OW + 1;
    // Byte offset within a line of 16-bit words spans OW+1 bits.
    localparam logic [ADDR_WIDTH-1:0] LINE_MASK = ADDR_WIDTH'(2 * LINE_WORDS - 1);

    fill_state_t           state, state_nx;
    logic [0:0]            state_q, state_d;
    logic [CW-1:0]         issue_cnt, recv_cnt;
    logic [ADDR_WIDTH-1:0] line_base;
    logic                  in_fill, issuing, recv_last;

    assign state_d = state_nx;
    assign state   = fill_state_t'(state_q);

    dff #(.W(1), .RST_VAL(1'b0)) u_state (
        .clk   (clk),
        .rst_n (rst_n),
        .d     (state_d),
        .q     (state_q)
    );

    assign in_fill   = (state == FILL);
    assign issuing   = in_fill && (issue_cnt < CW'(LINE_WORDS));
    assign recv_last = in_fill && memory_data_valid && (recv_cnt == CW'(LINE_WORDS - 1));

    // Counters are held cleared in IDLE so they start at zero on the first FILL cycle.
    cache_fill_counter #(.W(CW)) u_issue_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .en    (issuing),
        .cnt   (issue_cnt)
    );

    cache_fill_counter #(.W(CW)) u_recv_cnt (
        .clk   (clk),
        .rst_n (rst_n),
        .clr   (!in_fill),
        .en    (in_fill && memory_data_valid),
        .cnt   (recv_cnt)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            line_base <= '0;
        else if (!in_fill && miss_detected)
            line_base <= miss_address & ~LINE_MASK;
    end

    assign fill_line_address = line_base;

    always_comb begin
        state_nx          = state;
        fsm_busy          = 1'b0;
        mem_read          = 1'b0;
        memory_address    = '0;
        write_data_array  = 1'b0;
        cache_word_offset = '0;
        cache_write_data  = '0;
        write_tag_array   = 1'b0;
        case (state)
            IDLE: begin
                fsm_busy = miss_detected;
                if (miss_detected) state_nx = FILL;
            end
            FILL: begin
                fsm_busy = 1'b1;
                if (issuing) begin
                    mem_read       = 1'b1;
                    // Low line bits of line_base are zero, so OR never carries past the offset.
                    memory_address = line_base | ADDR_WIDTH'({issue_cnt[OW-1:0], 1'b0});
                end
                if (memory_data_valid) begin
                    write_data_array  = 1'b1;
                    cache_word_offset = recv_cnt[OW-1:0];
                    cache_write_data  = memory_data_out;
                end
                if (recv_last) begin
                    write_tag_array = 1'b1;
                    state_nx        = IDLE;
                end
            end
            default: state_nx = IDLE;
        endcase
    end
endmodule
